// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector slice assembler and its slot register.
package vector_pkg;

    // Assembler control states: collecting scalars, or holding a complete vector.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Bit offset of slot `index` inside a packed vector of `scalar_bits`-wide slots.
    function automatic int unsigned slice_offset(input int unsigned index,
                                                 input int unsigned scalar_bits);
        return index * scalar_bits;
    endfunction

endpackage

// File: rtl/vector_slice_assembler_if.sv
// Scalar-in / vector-out bus of the vector slice assembler.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid must keep its
// payload stable until the transfer; ready may depend combinationally on the
// other side's ready (in_ready follows out_ready while a vector is held).
interface vector_slice_assembler_if #(
    parameter int SCALAR_BITS = 32,
    parameter int LENGTH      = 5
);
    localparam int COUNT_WIDTH = $clog2(LENGTH + 1);
    localparam int SIZE_BITS   = LENGTH * SCALAR_BITS;

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [SCALAR_BITS-1:0] in_scalar;
    logic                   out_valid;
    logic                   out_ready;
    logic [SIZE_BITS-1:0]   out;
    logic [COUNT_WIDTH-1:0] fill_count;

    // Environment side: scalar producer plus vector consumer.
    modport master (
        output flush,
        output in_valid,
        output in_scalar,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  fill_count
    );

    // Assembler side.
    modport slave (
        input  flush,
        input  in_valid,
        input  in_scalar,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output fill_count
    );

endinterface

// File: rtl/vector_reg_slice_write.sv
// LENGTH-slot packed register written one slot at a time; slots reset to zero.
import vector_pkg::*;

module vector_reg_slice_write #(
    parameter int SCALAR_BITS = 32,
    parameter int LENGTH      = 5,
    localparam int INDEX_WIDTH = $clog2(LENGTH),
    localparam int SIZE_BITS   = LENGTH * SCALAR_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [SCALAR_BITS-1:0] write_data,
    output logic [SIZE_BITS-1:0]   out
);

    logic [SIZE_BITS-1:0] data;

    // Slot storage: the addressed slot takes write_data; out-of-range indices write nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (write_enable) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (write_index == INDEX_WIDTH'(i)) begin
                    data[slice_offset(int'(i), SCALAR_BITS) +: SCALAR_BITS] <= write_data;
                end
            end
        end
    end

    assign out = data;

endmodule

// File: rtl/vector_slice_assembler.sv
// Collects scalars into a packed vector and offers the whole vector with
// valid/ready. A drain and the first scalar of the next vector may share a
// cycle, so back-to-back vectors stream at one vector per LENGTH cycles.
import vector_pkg::*;

module vector_slice_assembler #(
    parameter int SCALAR_BITS = 32,
    parameter int LENGTH      = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    vector_slice_assembler_if.slave   bus,
    output state_t                    dbg_state
);

    localparam int INDEX_WIDTH = $clog2(LENGTH);
    localparam int COUNT_WIDTH = $clog2(LENGTH + 1);
    localparam int SIZE_BITS   = LENGTH * SCALAR_BITS;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(LENGTH - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(LENGTH);

    state_t                 state;
    state_t                 state_next;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [INDEX_WIDTH-1:0] write_index_next;

    logic                   in_ready_c;
    logic                   out_valid_c;
    logic [COUNT_WIDTH-1:0] fill_count_c;
    logic                   in_hs;
    logic                   out_hs;
    logic [SIZE_BITS-1:0]   vector_q;

    // Handshakes as seen this cycle; in_ready already folds in flush.
    assign in_hs  = bus.in_valid && in_ready_c;
    assign out_hs = out_valid_c && bus.out_ready;

    // State and slot-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            write_index <= '0;
        end else begin
            state       <= state_next;
            write_index <= write_index_next;
        end
    end

    // Next state: flush wins; a drain may coincide with the write to slot 0.
    always_comb begin
        state_next       = state;
        write_index_next = write_index;
        if (bus.flush) begin
            state_next       = FILL;
            write_index_next = '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_hs) begin
                        if (write_index == LAST_INDEX) begin
                            state_next       = FULL;
                            write_index_next = '0;
                        end else begin
                            write_index_next = write_index + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        state_next       = FILL;
                        write_index_next = in_hs ? INDEX_WIDTH'(1) : '0;
                    end
                end
                default: begin
                    state_next       = FILL;
                    write_index_next = '0;
                end
            endcase
        end
    end

    // Outputs: only in_ready looks at inputs (out_ready and flush).
    always_comb begin
        in_ready_c   = 1'b0;
        out_valid_c  = 1'b0;
        fill_count_c = '0;
        case (state)
            FILL: begin
                in_ready_c   = !bus.flush;
                out_valid_c  = 1'b0;
                fill_count_c = COUNT_WIDTH'(write_index);
            end
            FULL: begin
                in_ready_c   = bus.out_ready && !bus.flush;
                out_valid_c  = 1'b1;
                fill_count_c = FULL_COUNT;
            end
            default: begin
                in_ready_c   = 1'b0;
                out_valid_c  = 1'b0;
                fill_count_c = '0;
            end
        endcase
    end

    // In FULL the index is already back at 0, so a same-cycle refill lands in slot 0.
    vector_reg_slice_write #(
        .SCALAR_BITS (SCALAR_BITS),
        .LENGTH      (LENGTH)
    ) u_slots (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (in_hs),
        .write_index  (write_index),
        .write_data   (bus.in_scalar),
        .out          (vector_q)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.fill_count = fill_count_c;
    assign bus.out        = vector_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_vector_slice_assembler.sv
// Self-checking bench for vector_slice_assembler (SCALAR_BITS=32, LENGTH=5).
import vector_pkg::*;

module tb_vector_slice_assembler;

    localparam int SB  = 32;
    localparam int LEN = 5;
    localparam int CW  = 3;
    localparam int VB  = SB * LEN;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    vector_slice_assembler_if #(.SCALAR_BITS(SB), .LENGTH(LEN)) bus ();

    vector_slice_assembler #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [VB-1:0] exp_q[$];
    logic [SB-1:0] cur[$];
    bit            m_full = 1'b0;
    int            vectors_made = 0;

    task automatic check(input string name, input logic [VB-1:0] act, input logic [VB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        m_full = 1'b0;
    endtask

    // Monitor: whenever a vector is offered it must equal the oldest expected
    // vector; a consumer transfer retires it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_unexpected: got %h expected no vector", bus.out);
                end else begin
                    check("out_vector", bus.out, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One cycle: drive inputs after the edge, check the control outputs
    // against the model, then advance the model to what the next edge does.
    task automatic step(input bit v, input logic [SB-1:0] s, input bit ordy, input bit fl,
                        output bit accepted);
        bit            m_in_ready;
        logic [VB-1:0] vec;
        @(posedge clk);
        #2;
        bus.in_valid  = v;
        bus.in_scalar = s;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        m_in_ready = !fl && (!m_full || ordy);
        check("in_ready", VB'(bus.in_ready), VB'(m_in_ready));
        check("out_valid", VB'(bus.out_valid), VB'(m_full));
        check("fill_count", VB'(bus.fill_count), VB'(m_full ? LEN : cur.size()));
        accepted = v && m_in_ready;
        if (fl) begin
            cur.delete();
            if (m_full) begin
                m_full = 1'b0;
                void'(exp_q.pop_back());
            end
        end else begin
            if (m_full && ordy) m_full = 1'b0;
            if (accepted) begin
                cur.push_back(s);
                if (cur.size() == LEN) begin
                    vec = '0;
                    for (int i = 0; i < LEN; i++) vec[i*SB +: SB] = cur[i];
                    exp_q.push_back(vec);
                    cur.delete();
                    m_full = 1'b1;
                    vectors_made++;
                end
            end
        end
    endtask

    task automatic idle(input bit ordy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, acc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit            acc;
        logic [SB-1:0] val;
        int            cycles;
        int            target;
        logic [VB-1:0] basic_vec;

        bus.in_valid  = 1'b0;
        bus.in_scalar = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        basic_vec     = 160'h00000055_00000044_00000033_00000022_00000011;

        // Reset
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        check("reset_out", bus.out, '0);
        idle(1'b0, 1);

        // Basic fill with the consumer stalled
        for (int i = 1; i <= LEN; i++) step(1'b1, SB'(i * 'h11), 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("basic_vector", bus.out, basic_vec);
        check("basic_state", VB'(dbg_state), VB'(FULL));

        // Backpressure, then streaming with in_valid held high
        for (int i = 0; i < 3; i++) step(1'b1, 32'hA0, 1'b0, 1'b0, acc);
        val = 32'hA0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, val, 1'b1, 1'b0, acc);
            if (acc) val = val + 1;
        end
        check("stream_accepted", VB'(val), VB'(32'hA0 + 12));

        // Flush mid-fill drops the offered scalar
        step(1'b0, '0, 1'b1, 1'b1, acc);
        for (int i = 1; i <= 3; i++) step(1'b1, SB'(i), 1'b0, 1'b0, acc);
        step(1'b1, 32'h99, 1'b0, 1'b1, acc);
        check("flush_drop", VB'(acc), '0);
        for (int i = 0; i < LEN; i++) step(1'b1, SB'(32'hB0 + i), 1'b0, 1'b0, acc);
        idle(1'b0, 2);
        // Flush while a vector is held discards it
        step(1'b1, 32'hEE, 1'b0, 1'b1, acc);
        idle(1'b1, 2);

        // Asynchronous reset between edges after two writes
        step(1'b1, 32'hC1, 1'b0, 1'b0, acc);
        step(1'b1, 32'hC2, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_out_valid", VB'(bus.out_valid), '0);
        check("areset_fill_count", VB'(bus.fill_count), '0);
        check("areset_out", bus.out, '0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < LEN; i++) step(1'b1, SB'(32'hD0 + i), 1'b0, 1'b0, acc);
        idle(1'b1, 2);

        // Random in_valid gaps and consumer stalls over 50 vectors
        target = vectors_made + 50;
        cycles = 0;
        while (vectors_made < target && cycles < 3000) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, 1'b0, acc);
            cycles++;
        end
        check("random_vectors_done", VB'(vectors_made >= target), VB'(1));
        idle(1'b1, 3);
        check("queue_empty", VB'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
